uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the byte width of each stored entry.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning log2 of the FIFO depth (default depth 8).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 push  input  1  write strobe; connects to the receiver's one-cycle rx_done pulse.
REQ-006 push_data  input  DATA_W  byte to write; connects to the receiver's rx_data, sampled when push=1.
REQ-007 pop  input  1  read-acknowledge strobe from the consumer.
REQ-008 pop_data  output  DATA_W  head-of-queue byte, first-word-fall-through.
REQ-009 empty  output  1  high when count=0.
REQ-010 full  output  1  high when count=2^ADDR_W.
REQ-011 count  output  ADDR_W+1  number of stored entries, range 0..2^ADDR_W.
REQ-012 overflow  output  1  sticky flag; set when a byte was dropped.
REQ-013 clr_ovf  input  1  synchronous clear for overflow.

Function
REQ-014 Storage SHALL be 2^ADDR_W entries of DATA_W bits, addressed by wr_ptr and rd_ptr of ADDR_W bits each; both pointers SHALL wrap modulo 2^ADDR_W.
REQ-015 count, empty, full and overflow SHALL be registered outputs; empty and full SHALL be decoded from count only.
REQ-016 pop_data SHALL equal mem[rd_ptr] combinationally when empty=0 and SHALL be all-zero when empty=1.
REQ-017 Accepted push (push=1 and (full=0 or pop=1)): write push_data at wr_ptr; wr_ptr+1 on the same edge.
REQ-018 Accepted pop (pop=1 and empty=0): rd_ptr+1 on the edge; the next head SHALL be visible on pop_data the following cycle.
REQ-019 Write latency: a byte pushed into an empty FIFO SHALL appear on pop_data, with empty=0, in the cycle after the push edge.
REQ-020 count SHALL be +1 for push only, -1 for pop only, and unchanged when both are accepted or neither is.
REQ-021 Push while full with pop=0: byte dropped, pointers and count unchanged, overflow set to 1.
REQ-022 Push and pop both high while full: both accepted, count stays 2^ADDR_W, overflow not set.
REQ-023 Push and pop both high while empty: push accepted, pop ignored, count becomes 1; no bypass of push_data to pop_data in that cycle.
REQ-024 Pop while empty: ignored; no pointer or count change, no error flag.
REQ-025 Overflow SHALL remain 1 until clr_ovf=1 or rst=1.
REQ-026 If a drop event and clr_ovf=1 occur in the same cycle, the set SHALL win.
REQ-027 Storage contents SHALL NOT require reset; correctness SHALL rely only on the pointers and count.

Reset
REQ-028 rst=1 SHALL force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0 and pop_data=0 on the next edge.
REQ-029 rst SHALL take priority over push, pop and clr_ovf.
REQ-030 rst asserted mid-operation SHALL discard all stored bytes; the first push after rst deasserts SHALL be the new head.

Verification
REQ-031 Single byte: rst, push 0x41 for one cycle -> next cycle empty=0, count=1, pop_data=0x41; then pop -> next cycle empty=1, pop_data=0x00.
REQ-032 Fill and order: push 0x01..0x08 on consecutive cycles -> full=1, count=8; then 8 pops -> bytes read back 0x01..0x08 in order, ending with empty=1.
REQ-033 Overflow: with FIFO full, push 0x99 -> overflow=1, count=8, head still 0x01. Then clr_ovf -> overflow=0. Then drop plus clr_ovf in the same cycle -> overflow=1.
REQ-034 Simultaneous: while full, push 0xAA with pop -> count=8 and 0xAA is read last. While empty, push 0x55 with pop -> count=1 and pop_data=0x55 the next cycle.
REQ-035 Wrap-around: 20 interleaved push/pop pairs of an incrementing pattern with count held at 1..3 -> every byte returned in order and the pointers wrap without loss.
REQ-036 Reset mid-run: with count=5, assert rst -> count=0, empty=1, overflow=0. Then push 0x33 -> pop_data=0x33.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO that sits between a UART receiver and its consumer.
// The receiver's one-cycle rx_done pulse drives push, and its rx_data drives
// push_data. The consumer sees the oldest byte on pop_data without a read
// delay (first-word-fall-through) and acknowledges it with pop.
// Bytes arriving while the FIFO is full, and not matched by a pop in the same
// cycle, are dropped and recorded in a sticky overflow flag.

module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Storage array; it carries no reset because the pointers and count
    // alone decide which entries are meaningful.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              push_ok;
    logic              pop_ok;
    logic              drop;
    logic [ADDR_W:0]   count_next;

    // Accept/drop decisions for this cycle. A push into a full FIFO is still
    // taken when a pop frees the slot on the same edge; a pop on an empty
    // FIFO is simply ignored, so a simultaneous push+pop on empty is a pure
    // push with no bypass to pop_data.
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Next occupancy: one up for push only, one down for pop only, and
    // unchanged when both or neither are accepted.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    // Byte write into the array at the write pointer.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, occupancy and flag registers. empty and full are registered
    // decodes of the next count so they always agree with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH_CNT);
        end
    end

    // Sticky overflow flag; a drop in the same cycle as clr_ovf keeps it set
    // so that no lost byte goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Head-of-queue output; forced to zero whenever nothing valid is stored.
    always_comb begin
        pop_data = '0;
        if (!empty) begin
            pop_data = mem[rd_ptr];
        end
    end

endmodule
